// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide data RAM. Sub-word stores are done as read-modify-write,
// and load data is sign- or zero-extended before it is returned.
module lsu_mem_master #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic        mem_re,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {StIdle, StRd, StRmwRd, StWr, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        err_q, err_d;

    logic        req_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    always_comb begin
        req_err = (req_addr >= 32'(MEM_BYTES));
        case (req_funct3)
            3'b000:  req_err = req_err;
            3'b001:  req_err = req_err | req_addr[0];
            3'b010:  req_err = req_err | (req_addr[1:0] != 2'b00);
            3'b100:  req_err = req_err | req_we;
            3'b101:  req_err = req_err | req_we | req_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        ld_byte = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
        ld_half = mem_read_data[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_read_data;
        endcase
        // funct3[0] distinguishes SH from SB; only those two reach RMW_RD.
        merged = mem_read_data;
        if (funct3_q[0]) begin
            merged[{addr_q[1], 4'b0000} +: 16] = word_q[15:0];
        end else begin
            merged[{addr_q[1:0], 3'b000} +: 8] = word_q[7:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        word_d   = word_q;
        rdata_d  = rdata_q;
        funct3_d = funct3_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    word_d   = req_wdata;
                    funct3_d = req_funct3;
                    rdata_d  = '0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = StResp;
                    end else if (!req_we) begin
                        state_d = StRd;
                    end else if (req_funct3 == 3'b010) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StRd: begin
                rdata_d = ld_ext;
                state_d = StResp;
            end
            StRmwRd: begin
                word_d  = merged;
                state_d = StWr;
            end
            StWr:   state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            funct3_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
            funct3_q <= funct3_d;
            err_q    <= err_d;
        end
    end

    // Strobes are gated by rst so a reset landing in WR never reaches the RAM.
    assign req_ready      = (state_q == StIdle);
    assign resp_valid     = (state_q == StResp);
    assign resp_rdata     = (state_q == StResp) ? rdata_q : '0;
    assign resp_err       = (state_q == StResp) && err_q;
    assign mem_re         = ((state_q == StRd) || (state_q == StRmwRd)) && !rst;
    assign mem_we         = (state_q == StWr) && !rst;
    assign mem_address    = {addr_q[31:2], 2'b00};
    assign mem_write_data = (state_q == StWr) ? word_q : '0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed and randomized checks of lsu_mem_master against a word-array memory model.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    logic [31:0] ram     [0:1023];
    logic [31:0] ref_mem [0:1023];

    int total = 0;
    int bad   = 0;

    lsu_mem_master #(.MEM_BYTES(4096)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = ram[mem_address[11:2]];
    always @(posedge clk) if (mem_we) ram[mem_address[11:2]] <= mem_write_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic e;
        e = (a >= 32'd4096) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        if (we && f3 > 3'd2) e = 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) e = 1'b1;
        if (f3 == 3'd2 && a[1:0] != 2'd0) e = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] a);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [1:0] a, input logic [31:0] d);
        logic [31:0] sh;
        if (f3 == 3'd2) return d;
        if (f3 == 3'd0) begin
            sh = 8 * a;
            return (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        end
        sh = 16 * a[1];
        return (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
    endfunction

    // One request from IDLE to its response; checks latency, data, strobes and stored word.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] got);
        logic        err;
        int          lat_exp, lat, re_n, we_n, both_n, we_at, we_at_exp;
        logic [31:0] rd_exp, new_word;
        bit          seen;
        err       = model_err(we, f3, a);
        lat_exp   = err ? 1 : ((!we || f3 == 3'd2) ? 2 : 3);
        rd_exp    = (err || we) ? 32'h0 : load_ext(ref_mem[a[11:2]], f3, a[1:0]);
        new_word  = store_merge(ref_mem[a[11:2]], f3, a[1:0], wd);
        we_at_exp = (!err && we) ? lat_exp - 1 : 0;
        got = 32'hx;
        @(negedge clk);
        check("ready_idle", {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        re_n = 0; we_n = 0; both_n = 0; we_at = 0; lat = 0; seen = 0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = $urandom;
            if (k == 1) check("mem_address", mem_address, {a[31:2], 2'b00});
            if (mem_re) re_n++;
            if (mem_we) begin we_n++; we_at = k; end
            if (mem_re && mem_we) both_n++;
            if (resp_valid) begin
                seen = 1; lat = k; got = resp_rdata;
                check("resp_rdata", resp_rdata, rd_exp);
                check("resp_err", {31'h0, resp_err}, {31'h0, err});
                if (!err && we) check("ram_word", ram[a[11:2]], new_word);
            end else begin
                check("ready_busy", {31'h0, req_ready}, 32'd0);
            end
        end
        check("latency", 32'(lat), 32'(lat_exp));
        check("re_count", 32'(re_n), (!err && (!we || f3 != 3'd2)) ? 32'd1 : 32'd0);
        check("we_count", 32'(we_n), (!err && we) ? 32'd1 : 32'd0);
        check("we_timing", 32'(we_at), 32'(we_at_exp));
        check("re_we_excl", 32'(both_n), 32'd0);
        if (!err && we) ref_mem[a[11:2]] = new_word;
    endtask

    initial begin
        logic [31:0] got;
        logic [2:0]  f3_tab [7];
        logic [2:0]  f3;
        logic [31:0] a;
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'd1);
        check("rst_resp", {29'h0, resp_valid, resp_err, mem_we | mem_re}, 32'd0);
        check("rst_addr", mem_address, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_wdata", mem_write_data, 32'h0);
        rst = 1'b0;

        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, got);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, got);
        check("lw_10", got, 32'hDEADBEEF);

        do_req(1'b1, 3'd2, 32'h20, 32'h11223344, got);
        do_req(1'b1, 3'd0, 32'h22, 32'h000000AB, got);
        check("sb_22", ram[8], 32'h11AB3344);
        do_req(1'b1, 3'd1, 32'h20, 32'h0000BEEF, got);
        check("sh_20", ram[8], 32'h11ABBEEF);

        do_req(1'b1, 3'd2, 32'h30, 32'h80F07F01, got);
        do_req(1'b0, 3'd0, 32'h33, 32'h0, got);  check("lb_33", got, 32'hFFFFFF80);
        do_req(1'b0, 3'd4, 32'h33, 32'h0, got);  check("lbu_33", got, 32'h00000080);
        do_req(1'b0, 3'd0, 32'h30, 32'h0, got);  check("lb_30", got, 32'h00000001);
        do_req(1'b0, 3'd1, 32'h32, 32'h0, got);  check("lh_32", got, 32'hFFFF80F0);
        do_req(1'b0, 3'd5, 32'h32, 32'h0, got);  check("lhu_32", got, 32'h000080F0);

        do_req(1'b0, 3'd2, 32'h12, 32'h0, got);
        do_req(1'b1, 3'd1, 32'h31, 32'h1234, got);
        do_req(1'b0, 3'd3, 32'h10, 32'h0, got);
        do_req(1'b0, 3'd2, 32'h1000, 32'h0, got);
        do_req(1'b1, 3'd4, 32'h10, 32'h55, got);
        check("err_no_write", ram[4], 32'hDEADBEEF);

        // Held req_valid: accept, RD, RESP, then a fresh accept in IDLE.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h30;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("b2b_ready", {31'h0, req_ready}, (k % 3 == 0) ? 32'd1 : 32'd0);
            check("b2b_resp", {31'h0, resp_valid}, (k % 3 == 2) ? 32'd1 : 32'd0);
            if (k % 3 == 2) check("b2b_rdata", resp_rdata, 32'h80F07F01);
            if (k == 9) req_valid = 1'b0;
        end

        // Reset during the WR cycle of an SB drops the write and the response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h21;
        req_wdata = 32'h77;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rmw_re", {31'h0, mem_re}, 32'd1);
        @(negedge clk);
        check("wr_we", {31'h0, mem_we}, 32'd1);
        rst = 1'b1;
        #1 check("wr_gated", {31'h0, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_wr_ready", {31'h0, req_ready}, 32'd1);
        check("rst_wr_resp", {31'h0, resp_valid}, 32'd0);
        @(negedge clk);
        check("rst_wr_noresp", {31'h0, resp_valid}, 32'd0);
        check("rst_wr_ram", ram[8], ref_mem[8]);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, got);
        check("lw_after_rst", got, 32'h11ABBEEF);

        for (int i = 0; i < 16; i++) do_req(1'b1, 3'd2, 32'(i * 4), $urandom, got);
        for (int i = 0; i < 60; i++) begin
            f3 = f3_tab[$urandom_range(0, 6)];
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 4) != 0) begin
                if (f3 == 3'd2) a[1:0] = 2'b00;
                if (f3 == 3'd1 || f3 == 3'd5) a[0] = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) a = a + 32'h1000;
            do_req(1'($urandom_range(0, 1)), f3, a, $urandom, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
